wbconsole_ng: RTL and testbench
===============================

WBCONSOLE_NG -- requirements
Module: wbconsole_ng

Interface
REQ-001 SHALL provide parameter DW, default 8: UART character width in bits, legal range 5..8.
REQ-002 SHALL provide parameter LGFLEN, default 5: log2 of RX and TX FIFO depth, legal range 2..10.
REQ-003 SHALL provide ports, one clock, reset asynchronous active-high:
- i_clk  in  1  clock
- i_reset  in  1  async active-high reset
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  Wishbone control
- i_wb_addr  in  2  register select: 0 SETUP, 1 FIFO, 2 RXREG, 3 TXREG
- i_wb_data  in  32  write data
- i_wb_sel  in  4  byte selects
- o_wb_stall  out  1  always 0
- o_wb_ack  out  1  acknowledge
- o_wb_data  out  32  read data
- o_uart_stb  out  1  TX character available
- o_uart_data  out  DW  TX character (FIFO head)
- i_uart_busy  in  1  transmitter busy
- i_uart_stb  in  1  RX character valid
- i_uart_data  in  DW  RX character
- o_rx_int, o_rxfifo_int, o_tx_int, o_txfifo_int, o_rxto_int  out  1 each  interrupts

Function
REQ-004 SHALL contain two independent first-word-fall-through FIFOs, depth 2^LGFLEN, with fill counters LGFLEN+1 bits wide.
REQ-005 SHALL ack every strobe exactly one cycle later when i_wb_cyc stays high; ack dropped when i_wb_cyc is low; never stall.
REQ-006 SHALL register read data alongside ack, from the state sampled on the strobe cycle.
REQ-007 SETUP read: [15:0] timeout value; write with i_wb_sel[1:0]==2'b11 loads [15:0] and resets both FIFOs and all sticky flags.
REQ-008 FIFO read: [31:16] TX fill count, [15:0] RX fill count, zero-extended; writes ignored.
REQ-009 RXREG read: [DW-1:0] head character, [8] empty, [9] RX overflow sticky, [10] RX timeout flag; pops one entry when non-empty and i_wb_sel[0].
REQ-010 RXREG read while empty SHALL return [8]=1 and not change fill.
REQ-011 RXREG write: i_wb_sel[1] with data[9] clears RX overflow; with data[12] resets RX FIFO.
REQ-012 i_uart_stb SHALL push when not full; push while full with no same-cycle pop SHALL drop the character and set RX overflow; push and pop in the same cycle while full SHALL be accepted.
REQ-013 TXREG write with i_wb_sel[0] SHALL push data[DW-1:0]; push while full with no same-cycle drain SHALL drop and set TX overflow sticky; push and drain in the same cycle while full SHALL be accepted.
REQ-014 TXREG write: i_wb_sel[1] with data[9] clears TX overflow; with data[12] resets TX FIFO.
REQ-015 TXREG read: [8] full, [9] TX overflow, [10] busy = i_uart_busy or TX non-empty; no side effect.
REQ-016 o_uart_stb SHALL equal TX non-empty; o_uart_data SHALL equal TX head; drain on o_uart_stb && !i_uart_busy.
REQ-017 Interrupts: o_rx_int = RX non-empty; o_rxfifo_int = RX fill >= 2^(LGFLEN-1); o_tx_int = TX not full; o_txfifo_int = TX fill < 2^(LGFLEN-1); o_rxto_int = RX timeout flag.
REQ-018 Fill counters SHALL wrap pointers modulo depth; counters never exceed 2^LGFLEN nor underflow.

Reset
REQ-019 i_reset SHALL asynchronously clear FIFOs, pointers, sticky flags, timeout value and counter, o_wb_ack, o_wb_data.
REQ-020 After reset: o_uart_stb=0, o_rx_int=0, o_rxfifo_int=0, o_tx_int=1, o_txfifo_int=1, o_rxto_int=0.
REQ-021 Reset asserted mid-transaction SHALL suppress that ack.

Configuration
REQ-022 Macro WBCONSOLE_RX_TIMEOUT_EN SHALL compile in the RX idle timeout.
REQ-023 Defined: 16-bit counter clears on every RX push or pop and while RX empty, otherwise increments each cycle; reaching nonzero timeout value sets RX timeout flag, cleared by pop, RX reset or SETUP write; timeout value 0 disables.
REQ-024 Undefined: counter absent; timeout flag and o_rxto_int tied 0; SETUP reads 0.

Verification
REQ-025 Reset, read FIFO -> 0x00000000; o_tx_int=1, o_txfifo_int=1.
REQ-026 LGFLEN=2: push 0x41..0x45 on i_uart_stb -> fill 4, RXREG[9]=1; four RXREG reads return 0x41..0x44, fifth returns [8]=1.
REQ-027 Write TXREG 0x55 with i_uart_busy=1 for 3 cycles -> o_uart_stb=1, o_uart_data=0x55; drains the cycle busy drops, then o_uart_stb=0.
REQ-028 Macro defined, SETUP=10, push one RX character, idle -> o_rxto_int rises 10 cycles after push; RXREG read clears it.
REQ-029 LGFLEN=2 TX full, TXREG write same cycle as drain -> accepted, fill remains 4, TXREG[9]=0.
REQ-030 Write TXREG data[12]=1 sel=4'b0010 with 3 queued -> TX fill 0, o_uart_stb=0 next cycle.

Source files
------------

// File: rtl/wbconsole_ng.sv
// Wishbone console: RX/TX first-word-fall-through FIFOs between a bus slave and a UART core.
// Defining WBCONSOLE_RX_TIMEOUT_EN compiles in the RX idle timeout.

module wbconsole_ng_fifo #(
    parameter int DW     = 8,
    parameter int LGFLEN = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr,
    input  logic              rd,
    input  logic [DW-1:0]     din,
    output logic [DW-1:0]     head,
    output logic [LGFLEN:0]   fill,
    output logic              empty,
    output logic              full
);
    localparam logic [LGFLEN:0] DEPTH = (LGFLEN+1)'(1 << LGFLEN);

    logic [DW-1:0]     mem [0:(1<<LGFLEN)-1];
    logic [LGFLEN-1:0] wptr, rptr;

    always_ff @(posedge clk)
        if (wr) mem[wptr] <= din;

    // wr/rd arrive pre-qualified by the owner, so a write into a full FIFO only
    // happens together with a read of the same slot's old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            fill <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
            fill <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            fill <= fill + (LGFLEN+1)'(wr) - (LGFLEN+1)'(rd);
        end
    end

    assign head  = mem[rptr];
    assign empty = (fill == '0);
    assign full  = (fill == DEPTH);
endmodule

module wbconsole_ng #(
    parameter int DW     = 8,
    parameter int LGFLEN = 5
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    input  logic          i_wb_we,
    input  logic [1:0]    i_wb_addr,
    input  logic [31:0]   i_wb_data,
    input  logic [3:0]    i_wb_sel,
    output logic          o_wb_stall,
    output logic          o_wb_ack,
    output logic [31:0]   o_wb_data,
    output logic          o_uart_stb,
    output logic [DW-1:0] o_uart_data,
    input  logic          i_uart_busy,
    input  logic          i_uart_stb,
    input  logic [DW-1:0] i_uart_data,
    output logic          o_rx_int,
    output logic          o_rxfifo_int,
    output logic          o_tx_int,
    output logic          o_txfifo_int,
    output logic          o_rxto_int
);
    localparam logic [LGFLEN:0] HALF = (LGFLEN+1)'(1 << (LGFLEN-1));

    typedef enum logic [1:0] {A_SETUP = 2'd0, A_FIFO = 2'd1, A_RXREG = 2'd2, A_TXREG = 2'd3} addr_t;

    addr_t             reg_sel;
    logic              stb, wr_stb, rd_stb, ack;
    logic              setup_wr, rx_clr, tx_clr, rx_ovf_clr, tx_ovf_clr;
    logic              rx_push, rx_pop, rx_drop, tx_req, tx_push, tx_drain, tx_drop;
    logic              rx_empty, rx_full, tx_empty, tx_full;
    logic              rx_ovf, tx_ovf, rx_tof;
    logic [LGFLEN:0]   rx_fill, tx_fill;
    logic [DW-1:0]     rx_head, tx_head;
    logic [15:0]       tmo;
    logic [31:0]       rdata;
    logic              unused_bits;

    assign reg_sel  = addr_t'(i_wb_addr);
    assign stb      = i_wb_cyc && i_wb_stb;
    assign wr_stb   = stb && i_wb_we;
    assign rd_stb   = stb && !i_wb_we;

    assign setup_wr   = wr_stb && (reg_sel == A_SETUP) && (i_wb_sel[1:0] == 2'b11);
    assign rx_ovf_clr = wr_stb && (reg_sel == A_RXREG) && i_wb_sel[1] && i_wb_data[9];
    assign tx_ovf_clr = wr_stb && (reg_sel == A_TXREG) && i_wb_sel[1] && i_wb_data[9];
    assign rx_clr     = setup_wr || (wr_stb && (reg_sel == A_RXREG) && i_wb_sel[1] && i_wb_data[12]);
    assign tx_clr     = setup_wr || (wr_stb && (reg_sel == A_TXREG) && i_wb_sel[1] && i_wb_data[12]);

    assign rx_pop   = rd_stb && (reg_sel == A_RXREG) && i_wb_sel[0] && !rx_empty;
    assign rx_push  = i_uart_stb && (!rx_full || rx_pop);
    assign rx_drop  = i_uart_stb && rx_full && !rx_pop;

    assign tx_drain = !tx_empty && !i_uart_busy;
    assign tx_req   = wr_stb && (reg_sel == A_TXREG) && i_wb_sel[0];
    assign tx_push  = tx_req && (!tx_full || tx_drain);
    assign tx_drop  = tx_req && tx_full && !tx_drain;

    wbconsole_ng_fifo #(.DW(DW), .LGFLEN(LGFLEN)) rx_fifo (
        .clk(i_clk), .rst(i_reset), .clr(rx_clr), .wr(rx_push), .rd(rx_pop),
        .din(i_uart_data), .head(rx_head), .fill(rx_fill), .empty(rx_empty), .full(rx_full)
    );

    wbconsole_ng_fifo #(.DW(DW), .LGFLEN(LGFLEN)) tx_fifo (
        .clk(i_clk), .rst(i_reset), .clr(tx_clr), .wr(tx_push), .rd(tx_drain),
        .din(i_wb_data[DW-1:0]), .head(tx_head), .fill(tx_fill), .empty(tx_empty), .full(tx_full)
    );

    // A drop in the same cycle as a software clear leaves the flag set: that character is lost.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_ovf <= 1'b0;
            tx_ovf <= 1'b0;
        end else begin
            if (setup_wr)        rx_ovf <= 1'b0;
            else if (rx_drop)    rx_ovf <= 1'b1;
            else if (rx_ovf_clr) rx_ovf <= 1'b0;
            if (setup_wr)        tx_ovf <= 1'b0;
            else if (tx_drop)    tx_ovf <= 1'b1;
            else if (tx_ovf_clr) tx_ovf <= 1'b0;
        end
    end

`ifdef WBCONSOLE_RX_TIMEOUT_EN
    logic [15:0] tcnt;

    // tcnt counts idle cycles with data waiting; the flag fires on the cycle it reaches tmo.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tmo    <= '0;
            tcnt   <= '0;
            rx_tof <= 1'b0;
        end else begin
            if (setup_wr) tmo <= i_wb_data[15:0];
            if (rx_push || rx_pop || rx_empty || rx_clr) tcnt <= '0;
            else if (tcnt != 16'hffff)                   tcnt <= tcnt + 16'd1;
            if (rx_clr || rx_pop)
                rx_tof <= 1'b0;
            else if (!rx_push && !rx_empty && (tmo != '0) && (tcnt + 16'd1 == tmo))
                rx_tof <= 1'b1;
        end
    end
`else
    assign tmo    = '0;
    assign rx_tof = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (reg_sel)
            A_SETUP: rdata[15:0] = tmo;
            A_FIFO: begin
                rdata[16 +: LGFLEN+1] = tx_fill;
                rdata[LGFLEN:0]       = rx_fill;
            end
            A_RXREG: begin
                rdata[DW-1:0] = rx_head;
                rdata[8]      = rx_empty;
                rdata[9]      = rx_ovf;
                rdata[10]     = rx_tof;
            end
            default: begin
                rdata[8]  = tx_full;
                rdata[9]  = tx_ovf;
                rdata[10] = i_uart_busy || !tx_empty;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ack       <= 1'b0;
            o_wb_data <= '0;
        end else begin
            ack <= stb;
            if (stb) o_wb_data <= rdata;
        end
    end

    assign o_wb_ack     = ack && i_wb_cyc;
    assign o_wb_stall   = 1'b0;
    assign o_uart_stb   = !tx_empty;
    assign o_uart_data  = tx_head;
    assign o_rx_int     = !rx_empty;
    assign o_rxfifo_int = (rx_fill >= HALF);
    assign o_tx_int     = !tx_full;
    assign o_txfifo_int = (tx_fill < HALF);
    assign o_rxto_int   = rx_tof;
    assign unused_bits  = ^{i_wb_data, i_wb_sel};
endmodule

// File: tb/tb_wbconsole_ng.sv
// Bench for wbconsole_ng (LGFLEN=2): directed scenarios plus random traffic against a queue-based model.
module tb_wbconsole_ng;
    localparam int DEPTH = 4;
`ifdef WBCONSOLE_RX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 0, rst = 1;
    logic cyc = 0, stb = 0, we = 0;
    logic [1:0] addr = 0;
    logic [31:0] wdata = 0;
    logic [3:0] sel = 0;
    logic stall, ack;
    logic [31:0] rdata;
    logic uart_stb, uart_busy = 0, rx_stb = 0;
    logic [7:0] uart_data, rx_data = 0;
    logic rx_int, rxfifo_int, tx_int, txfifo_int, rxto_int;

    int n_tests = 0, n_fail = 0;

    // reference model state
    logic [7:0] rxq[$], txq[$];
    bit m_rxovf, m_txovf, m_tof, m_ack, m_rd;
    int m_idle;
    logic [15:0] m_tmo;
    logic [31:0] m_rdata, m_mask;

    wbconsole_ng #(.DW(8), .LGFLEN(2)) dut (
        .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_stall(stall),
        .o_wb_ack(ack), .o_wb_data(rdata), .o_uart_stb(uart_stb), .o_uart_data(uart_data),
        .i_uart_busy(uart_busy), .i_uart_stb(rx_stb), .i_uart_data(rx_data),
        .o_rx_int(rx_int), .o_rxfifo_int(rxfifo_int), .o_tx_int(tx_int),
        .o_txfifo_int(txfifo_int), .o_rxto_int(rxto_int)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_reset();
        rxq.delete(); txq.delete();
        m_rxovf = 0; m_txovf = 0; m_tof = 0; m_ack = 0; m_rd = 0;
        m_idle = 0; m_tmo = 0; m_rdata = 0; m_mask = '1;
    endtask

    // Advance the model by the rules of the register map using the currently driven inputs, then clock.
    task automatic tick();
        bit s, w, r, rxe, rxf, txe, txf, setup, rxrst, txrst, pop, drain, txw, pushed;
        logic [31:0] rd, msk;
        s = cyc && stb; w = s && we; r = s && !we;
        rxe = (rxq.size() == 0); rxf = (rxq.size() == DEPTH);
        txe = (txq.size() == 0); txf = (txq.size() == DEPTH);
        rd = '0; msk = '1;
        case (addr)
            2'd0: rd = TO_EN ? {16'h0, m_tmo} : 32'h0;
            2'd1: rd = (txq.size() << 16) | rxq.size();
            2'd2: begin
                rd[7:0] = rxe ? 8'h00 : rxq[0];
                rd[8] = rxe; rd[9] = m_rxovf; rd[10] = m_tof;
                if (rxe) msk = 32'hffff_ff00;
            end
            default: begin rd[8] = txf; rd[9] = m_txovf; rd[10] = uart_busy || !txe; end
        endcase
        m_ack = s; m_rd = r;
        if (s) begin m_rdata = rd; m_mask = msk; end
        setup = w && addr == 2'd0 && sel[1:0] == 2'b11;
        rxrst = setup || (w && addr == 2'd2 && sel[1] && wdata[12]);
        txrst = setup || (w && addr == 2'd3 && sel[1] && wdata[12]);
        pop   = r && addr == 2'd2 && sel[0] && !rxe;
        drain = !txe && !uart_busy;
        txw   = w && addr == 2'd3 && sel[0];
        if (setup) begin m_rxovf = 0; m_txovf = 0; end
        else begin
            if (rx_stb && rxf && !pop) m_rxovf = 1;
            else if (w && addr == 2'd2 && sel[1] && wdata[9]) m_rxovf = 0;
            if (txw && txf && !drain) m_txovf = 1;
            else if (w && addr == 2'd3 && sel[1] && wdata[9]) m_txovf = 0;
        end
        pushed = rx_stb && (!rxf || pop);
        if (rxrst) rxq.delete();
        else begin
            if (pop) void'(rxq.pop_front());
            if (pushed) rxq.push_back(rx_data);
        end
        if (txrst) txq.delete();
        else begin
            if (drain) void'(txq.pop_front());
            if (txw && (!txf || drain)) txq.push_back(wdata[7:0]);
        end
        if (TO_EN) begin
            if (rxrst || pop) m_tof = 0;
            if (pushed || pop || rxe || rxrst) m_idle = 0;
            else begin
                m_idle++;
                if (m_tmo != 0 && m_idle == m_tmo) m_tof = 1;
            end
            if (setup) m_tmo = wdata[15:0];
        end
        @(posedge clk); #1;
    endtask

    task automatic wb(input logic [1:0] a, input bit w, input logic [31:0] d, input logic [3:0] s);
        cyc = 1; stb = 1; we = w; addr = a; wdata = d; sel = s;
        tick();
        stb = 0; we = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack); end
        n_tests++; if (uart_stb !== 1'b0) begin n_fail++; $display("FAIL reset_uart_stb: got %b want 0", uart_stb); end
        n_tests++; if (rx_int !== 1'b0 || rxfifo_int !== 1'b0 || rxto_int !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ints: got %b%b%b want 000", rx_int, rxfifo_int, rxto_int); end
        n_tests++; if (tx_int !== 1'b1 || txfifo_int !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ints: got %b%b want 11", tx_int, txfifo_int); end
        rst = 0;
        model_reset();
        wb(2'd1, 0, 0, 4'hf);
        n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL reset_fifo_ack: got %b want 1", ack); end
        n_tests++; if (rdata !== 32'h0 || m_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_fifo_read: got %h want 00000000", rdata); end
        cyc = 0; tick();
    endtask

    task automatic test_reset_mid_txn();
        cyc = 1; stb = 1; we = 0; addr = 2'd1; sel = 4'hf;
        #2 rst = 1;
        @(posedge clk); #1;
        n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_mid_txn_ack: got %b want 0", ack); end
        stb = 0; rst = 0; cyc = 0;
        model_reset();
        tick();
    endtask

    task automatic test_rx_overflow();
        for (int i = 0; i < 5; i++) begin
            rx_stb = 1; rx_data = 8'h41 + 8'(i);
            tick();
        end
        rx_stb = 0;
        wb(2'd1, 0, 0, 4'hf);
        n_tests++; if (rdata[15:0] !== 16'd4 || rdata !== m_rdata) begin n_fail++; $display("FAIL rx_fill_full: got %h want %h", rdata, m_rdata); end
        for (int i = 0; i < 4; i++) begin
            wb(2'd2, 0, 0, 4'b0001);
            n_tests++; if (rdata[7:0] !== 8'h41 + 8'(i) || rdata[9:8] !== 2'b10 || (rdata & m_mask) !== (m_rdata & m_mask)) begin n_fail++; $display("FAIL rx_read_%0d: got %h want %h", i, rdata, m_rdata); end
        end
        wb(2'd2, 0, 0, 4'b0001);
        n_tests++; if (rdata[8] !== 1'b1 || (rdata & m_mask) !== (m_rdata & m_mask)) begin n_fail++; $display("FAIL rx_read_empty: got %h want %h", rdata, m_rdata); end
        wb(2'd1, 0, 0, 4'hf);
        n_tests++; if (rdata[15:0] !== 16'd0) begin n_fail++; $display("FAIL rx_fill_after_empty_read: got %h want 0", rdata[15:0]); end
        wb(2'd2, 1, 32'h200, 4'b0010);
        wb(2'd2, 0, 0, 4'b0000);
        n_tests++; if (rdata[9] !== 1'b0 || (rdata & m_mask) !== (m_rdata & m_mask)) begin n_fail++; $display("FAIL rx_ovf_clear: got %h want %h", rdata, m_rdata); end
        cyc = 0; tick();
    endtask

    task automatic test_tx_busy();
        uart_busy = 1;
        wb(2'd3, 1, 32'h55, 4'b0001);
        cyc = 0;
        n_tests++; if (uart_stb !== 1'b1 || uart_data !== 8'h55) begin n_fail++; $display("FAIL tx_busy_hold: got stb=%b data=%h want stb=1 data=55", uart_stb, uart_data); end
        for (int i = 0; i < 3; i++) tick();
        n_tests++; if (uart_stb !== 1'b1) begin n_fail++; $display("FAIL tx_busy_still: got %b want 1", uart_stb); end
        uart_busy = 0;
        tick();
        n_tests++; if (uart_stb !== 1'b0 || txq.size() != 0) begin n_fail++; $display("FAIL tx_drain: got %b want 0", uart_stb); end
    endtask

    task automatic test_tx_full_drain();
        uart_busy = 1;
        for (int i = 0; i < 4; i++) wb(2'd3, 1, 32'h60 + i, 4'b0001);
        wb(2'd3, 0, 0, 4'hf);
        n_tests++; if (rdata[10:8] !== 3'b101 || rdata !== m_rdata) begin n_fail++; $display("FAIL tx_full_status: got %h want %h", rdata, m_rdata); end
        uart_busy = 0;
        wb(2'd3, 1, 32'h70, 4'b0001);
        uart_busy = 1;
        wb(2'd1, 0, 0, 4'hf);
        n_tests++; if (rdata[31:16] !== 16'd4 || rdata !== m_rdata) begin n_fail++; $display("FAIL tx_fill_after_drain_push: got %h want %h", rdata, m_rdata); end
        wb(2'd3, 0, 0, 4'hf);
        n_tests++; if (rdata[9] !== 1'b0 || uart_data !== 8'h61) begin n_fail++; $display("FAIL tx_no_ovf: got %h head %h want bit9=0 head 61", rdata, uart_data); end
        wb(2'd3, 1, 32'h71, 4'b0001);
        wb(2'd3, 0, 0, 4'hf);
        n_tests++; if (rdata[9] !== 1'b1 || rdata !== m_rdata) begin n_fail++; $display("FAIL tx_ovf_set: got %h want %h", rdata, m_rdata); end
        wb(2'd3, 1, 32'h200, 4'b0010);
        wb(2'd3, 0, 0, 4'hf);
        n_tests++; if (rdata[9] !== 1'b0 || rdata !== m_rdata) begin n_fail++; $display("FAIL tx_ovf_clear: got %h want %h", rdata, m_rdata); end
        cyc = 0; tick();
    endtask

    task automatic test_tx_reset();
        uart_busy = 1;
        wb(2'd3, 1, 32'h1000, 4'b0010);
        for (int i = 0; i < 3; i++) wb(2'd3, 1, 32'h30 + i, 4'b0001);
        wb(2'd1, 0, 0, 4'hf);
        n_tests++; if (rdata[31:16] !== 16'd3) begin n_fail++; $display("FAIL tx_three_queued: got %0d want 3", rdata[31:16]); end
        wb(2'd3, 1, 32'h1000, 4'b0010);
        n_tests++; if (uart_stb !== 1'b0) begin n_fail++; $display("FAIL tx_reset_stb: got %b want 0", uart_stb); end
        wb(2'd1, 0, 0, 4'hf);
        n_tests++; if (rdata[31:16] !== 16'd0 || rdata !== m_rdata) begin n_fail++; $display("FAIL tx_reset_fill: got %h want %h", rdata, m_rdata); end
        uart_busy = 0; cyc = 0; tick();
    endtask

    task automatic test_timeout();
        int n;
        wb(2'd0, 1, 32'd10, 4'b0011);
        wb(2'd0, 0, 0, 4'hf);
        n_tests++; if (rdata[15:0] !== (TO_EN ? 16'd10 : 16'd0)) begin n_fail++; $display("FAIL setup_read: got %h want %h", rdata[15:0], TO_EN ? 16'd10 : 16'd0); end
        cyc = 0;
        rx_stb = 1; rx_data = 8'h33;
        tick();
        rx_stb = 0;
        n = 0;
        while (rxto_int !== 1'b1 && n < 40) begin
            tick();
            n++;
            n_tests++; if (rxto_int !== m_tof) begin n_fail++; $display("FAIL rxto_model_%0d: got %b want %b", n, rxto_int, m_tof); end
        end
        n_tests++; if (n !== (TO_EN ? 10 : 40)) begin n_fail++; $display("FAIL rxto_delay: got %0d want %0d", n, TO_EN ? 10 : 40); end
        wb(2'd2, 0, 0, 4'b0001);
        n_tests++; if (rdata[10] !== TO_EN || rdata[7:0] !== 8'h33) begin n_fail++; $display("FAIL rxto_read: got %h want bit10=%b data 33", rdata, TO_EN); end
        n_tests++; if (rxto_int !== 1'b0) begin n_fail++; $display("FAIL rxto_cleared: got %b want 0", rxto_int); end
        wb(2'd0, 1, 32'd0, 4'b0011);
        cyc = 0; tick();
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 600; c++) begin
            cyc = ($urandom_range(0, 9) != 0);
            stb = $urandom_range(0, 1);
            we  = $urandom_range(0, 1);
            r = $urandom_range(0, 15);
            addr = (r == 0) ? 2'd0 : (r < 4) ? 2'd1 : (r < 10) ? 2'd2 : 2'd3;
            sel = 4'($urandom);
            wdata = $urandom;
            if ($urandom_range(0, 7) != 0) wdata[12] = 1'b0;
            if (addr == 2'd0) wdata[15:0] = 16'($urandom_range(0, 12));
            rx_stb = ($urandom_range(0, 2) == 0);
            rx_data = 8'($urandom);
            uart_busy = ($urandom_range(0, 2) == 0);
            tick();
            n_tests++; if (ack !== m_ack || stall !== 1'b0) begin n_fail++; $display("FAIL rnd_ack_%0d: got %b/%b want %b/0", c, ack, stall, m_ack); end
            if (m_ack && m_rd) begin
                n_tests++; if ((rdata & m_mask) !== (m_rdata & m_mask)) begin n_fail++; $display("FAIL rnd_rdata_%0d: got %h want %h", c, rdata, m_rdata); end
            end
            n_tests++; if (uart_stb !== (txq.size() != 0) || (txq.size() != 0 && uart_data !== txq[0])) begin n_fail++; $display("FAIL rnd_uart_%0d: got %b %h want %0d queued", c, uart_stb, uart_data, txq.size()); end
            n_tests++; if ({rx_int, rxfifo_int, tx_int, txfifo_int, rxto_int} !== {rxq.size() != 0, rxq.size() >= DEPTH/2, txq.size() != DEPTH, txq.size() < DEPTH/2, m_tof}) begin n_fail++; $display("FAIL rnd_ints_%0d: got %b rx=%0d tx=%0d tof=%b", c, {rx_int, rxfifo_int, tx_int, txfifo_int, rxto_int}, rxq.size(), txq.size(), m_tof); end
        end
        cyc = 0; stb = 0; we = 0; rx_stb = 0; uart_busy = 0;
        tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_reset_mid_txn();
        test_rx_overflow();
        test_tx_busy();
        test_tx_full_drain();
        test_tx_reset();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
